mem_bus_arbiter: RTL and testbench
==================================

MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

Interface
REQ-001 Parameter AW, 8, address width in bits.
REQ-002 Parameter DW, 8, data width in bits.
REQ-003 clk  in  1  single system clock; all state changes on the rising edge.
REQ-004 reset  in  1  asynchronous, active-low reset.
REQ-005 r0_req / r1_req  in  1  access request from requester 0 (CPU) / requester 1 (DMA); held until the matching ack.
REQ-006 r0_we / r1_we  in  1  1 = write, 0 = read; valid while req is high.
REQ-007 r0_add / r1_add  in  AW  access address.
REQ-008 r0_wdat / r1_wdat  in  DW  write data.
REQ-009 r0_lock / r1_lock  in  1  keep ownership after the current access (read-modify-write).
REQ-010 r0_ack / r1_ack  out  1  one-cycle completion pulse.
REQ-011 r0_rdat / r1_rdat  out  DW  read data; valid in the ack cycle, held until the next ack to that port.
REQ-012 mem_add  out  AW  memory address.
REQ-013 mem_dout  out  DW  memory write data.
REQ-014 mem_din  in  DW  memory read data; combinational from mem_add.
REQ-015 mem_rd / mem_wrt  out  1  memory read / write strobes.
REQ-016 gnt  out  2  one-hot current owner; 2'b00 when idle.
REQ-017 busy  out  1  high in ACCESS and ACK.

Function
REQ-018 FSM states IDLE, ACCESS, ACK; IDLE->ACCESS when a grant is made, ACCESS->ACK always, ACK->IDLE always.
REQ-019 IDLE: sample requests, pick the winner, latch its we/add/wdat into internal registers, set gnt.
REQ-020 ACCESS: mem_add and mem_dout driven from the latched registers; mem_rd = !we, mem_wrt = we; strobes asserted for exactly one cycle.
REQ-021 mem_rd and mem_wrt never high together; both low outside ACCESS.
REQ-022 Read: mem_din captured into the owner's rdat at the ACCESS->ACK edge.
REQ-023 ACK: the owner's ack is high for one cycle; the other port's ack stays low.
REQ-024 Latency: ack is high exactly 2 cycles after the IDLE cycle in which req was sampled.
REQ-025 Throughput: one access per 3 cycles maximum.
REQ-026 req sampled only in IDLE; a req still high in the cycle after ack counts as a new request.
REQ-027 A req dropped after grant does not abort the access; the access completes and ack still pulses.
REQ-028 Single request: grant that requester.
REQ-029 Tie policy per REQ-035/REQ-036.
REQ-030 Lock: if the owner's lock is high in ACK, the next IDLE arbitration considers only that owner and keeps gnt.
REQ-031 Locked owner with req low: the arbiter waits in IDLE with gnt held and the other port blocked until lock drops.
REQ-032 gnt returns to 2'b00 in IDLE when no lock is held.

Reset
REQ-033 While reset is low: state = IDLE; gnt, busy, acks, mem_rd, mem_wrt = 0; mem_add, mem_dout, rdat = 0; lock ownership cleared; last-grant = requester 1.
REQ-034 Reset mid-ACCESS: strobes drop asynchronously, the write is abandoned, no ack is issued; arbitration resumes from IDLE after release.

Configuration
REQ-035 ARB_ROUND_ROBIN_EN defined: on a simultaneous request, grant the requester not granted last; last-grant updates on every grant; the first tie after reset goes to requester 0.
REQ-036 ARB_ROUND_ROBIN_EN undefined: fixed priority, requester 0 always wins ties; last-grant register absent.

Verification
REQ-037 r0 read, add=8'h10, mem[8'h10]=8'hA5 -> mem_rd high 1 cycle with mem_add=8'h10; r0_ack 2 cycles after sampling; r0_rdat=8'hA5.
REQ-038 r1 write, add=8'h20, wdat=8'h3C -> mem_wrt high 1 cycle, mem_dout=8'h3C, mem[8'h20]=8'h3C, r1_ack pulses, mem_rd low throughout.
REQ-039 r0 and r1 both held high for 4 accesses -> with macro: grant order r0,r1,r0,r1; without macro: r0 on every access while it requests.
REQ-040 r1 lock=1, read 8'h30 then write 8'h30 while r0 requests -> r0 not granted until r1 drops lock; r1 accesses back-to-back.
REQ-041 reset low during an ACCESS write to 8'h40 -> mem_wrt low immediately, no ack, gnt=00, busy=0; after release a fresh r0 request completes normally.

Source files
------------

// File: rtl/mem_bus_arbiter.sv
// Two-port (CPU / DMA) arbiter onto one memory bus: IDLE -> ACCESS -> ACK per transfer.
// Optional macro ARB_ROUND_ROBIN_EN gives round-robin ties; otherwise requester 0 wins ties.
module mem_bus_arbiter #(
    parameter int AW = 8,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          r0_req,
    input  logic          r1_req,
    input  logic          r0_we,
    input  logic          r1_we,
    input  logic [AW-1:0] r0_add,
    input  logic [AW-1:0] r1_add,
    input  logic [DW-1:0] r0_wdat,
    input  logic [DW-1:0] r1_wdat,
    input  logic          r0_lock,
    input  logic          r1_lock,
    output logic          r0_ack,
    output logic          r1_ack,
    output logic [DW-1:0] r0_rdat,
    output logic [DW-1:0] r1_rdat,
    output logic [AW-1:0] mem_add,
    output logic [DW-1:0] mem_dout,
    input  logic [DW-1:0] mem_din,
    output logic          mem_rd,
    output logic          mem_wrt,
    output logic [1:0]    gnt,
    output logic          busy,
    output logic [1:0]    fsm_state
);
    // Handshake: a requester raises req with we/add/wdat/lock stable and holds it until its
    // one-cycle ack; req is only looked at in IDLE, so a req still high after ack is a new request.
    typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, ACK = 2'd2} state_t;

    state_t        state, state_nxt;
    logic          owner;
    logic          lock_q;
    logic          we_q;
    logic [AW-1:0] add_q;
    logic [DW-1:0] wdat_q;
    logic [DW-1:0] rdat0_q, rdat1_q;
    logic [1:0]    gnt_q;
    logic          own_req, own_lock, hold, grant, win, tie_win;

`ifdef ARB_ROUND_ROBIN_EN
    logic last_q;
    assign tie_win = ~last_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            last_q <= 1'b1;
        else if (state == IDLE && grant)
            last_q <= win;
    end
`else
    assign tie_win = 1'b0;
`endif

    assign own_req  = owner ? r1_req  : r0_req;
    assign own_lock = owner ? r1_lock : r0_lock;
    // A locked owner that is not requesting parks the bus until it lets go of lock.
    assign hold     = lock_q && !own_req && own_lock;

    always_comb begin
        grant = 1'b0;
        win   = owner;
        if (lock_q && own_req) begin
            grant = 1'b1;
        end else if (!hold) begin
            if (r0_req && r1_req) begin
                grant = 1'b1;
                win   = tie_win;
            end else if (r0_req) begin
                grant = 1'b1;
                win   = 1'b0;
            end else if (r1_req) begin
                grant = 1'b1;
                win   = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        mem_rd    = 1'b0;
        mem_wrt   = 1'b0;
        r0_ack    = 1'b0;
        r1_ack    = 1'b0;
        busy      = 1'b0;
        case (state)
            IDLE: begin
                if (grant)
                    state_nxt = ACCESS;
            end
            ACCESS: begin
                state_nxt = ACK;
                mem_rd    = !we_q;
                mem_wrt   = we_q;
                busy      = 1'b1;
            end
            ACK: begin
                state_nxt = IDLE;
                r0_ack    = !owner;
                r1_ack    = owner;
                busy      = 1'b1;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            owner   <= 1'b0;
            lock_q  <= 1'b0;
            we_q    <= 1'b0;
            add_q   <= '0;
            wdat_q  <= '0;
            gnt_q   <= 2'b00;
            rdat0_q <= '0;
            rdat1_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (!hold)
                        lock_q <= 1'b0;
                    if (grant) begin
                        owner  <= win;
                        we_q   <= win ? r1_we   : r0_we;
                        add_q  <= win ? r1_add  : r0_add;
                        wdat_q <= win ? r1_wdat : r0_wdat;
                        gnt_q  <= {win, ~win};
                    end else if (!hold) begin
                        gnt_q <= 2'b00;
                    end
                end
                ACCESS: begin
                    if (!we_q) begin
                        if (owner)
                            rdat1_q <= mem_din;
                        else
                            rdat0_q <= mem_din;
                    end
                end
                ACK: begin
                    lock_q <= own_lock;
                    if (!own_lock)
                        gnt_q <= 2'b00;
                end
                default: ;
            endcase
        end
    end

    assign mem_add   = add_q;
    assign mem_dout  = wdat_q;
    assign r0_rdat   = rdat0_q;
    assign r1_rdat   = rdat1_q;
    assign gnt       = gnt_q;
    assign fsm_state = state;
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: directed scenarios plus randomized traffic
// checked against an access-order / memory reference model.
module tb_mem_bus_arbiter;
    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       r0_req, r1_req, r0_we, r1_we, r0_lock, r1_lock;
    logic [7:0] r0_add, r1_add, r0_wdat, r1_wdat;
    logic       r0_ack, r1_ack, mem_rd, mem_wrt, busy;
    logic [7:0] r0_rdat, r1_rdat, mem_add, mem_dout, mem_din;
    logic [1:0] gnt, fsm_state;

    logic [7:0] mem [256];
    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int rd_cnt = 0;
    int wr_cnt = 0;

    typedef struct { int c; int p; } ack_ev_t;
    ack_ev_t    ack_log[$];
    logic [1:0] exp_q[$];

    mem_bus_arbiter #(.AW(8), .DW(8)) dut (
        .clk(clk), .reset(reset),
        .r0_req(r0_req), .r1_req(r1_req), .r0_we(r0_we), .r1_we(r1_we),
        .r0_add(r0_add), .r1_add(r1_add), .r0_wdat(r0_wdat), .r1_wdat(r1_wdat),
        .r0_lock(r0_lock), .r1_lock(r1_lock), .r0_ack(r0_ack), .r1_ack(r1_ack),
        .r0_rdat(r0_rdat), .r1_rdat(r1_rdat), .mem_add(mem_add), .mem_dout(mem_dout),
        .mem_din(mem_din), .mem_rd(mem_rd), .mem_wrt(mem_wrt), .gnt(gnt), .busy(busy),
        .fsm_state(fsm_state)
    );

    // clock / memory environment
    always #5 clk = ~clk;
    assign mem_din = mem[mem_add];
    always @(posedge clk) if (mem_wrt) mem[mem_add] = mem_dout;

    always @(negedge clk) begin
        if (mem_rd) rd_cnt++;
        if (mem_wrt) wr_cnt++;
        if (r0_ack) ack_log.push_back('{cyc, 0});
        if (r1_ack) ack_log.push_back('{cyc, 1});
        if (reset) begin
            checks++;
            if ((mem_rd && mem_wrt) || (r0_ack && r1_ack)) begin
                errors++;
                $display("FAIL exclusive: rd=%b wrt=%b ack0=%b ack1=%b at cyc %0d", mem_rd, mem_wrt, r0_ack, r1_ack, cyc);
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // driver tasks
    task automatic tick();
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic drive(input int p, input logic req, input logic we, input logic [7:0] add,
                         input logic [7:0] wdat, input logic lock);
        if (p == 0) begin
            r0_req = req; r0_we = we; r0_add = add; r0_wdat = wdat; r0_lock = lock;
        end else begin
            r1_req = req; r1_we = we; r1_add = add; r1_wdat = wdat; r1_lock = lock;
        end
    endtask

    task automatic pulse_reset();
        drive(0, 0, 0, 8'h00, 8'h00, 0);
        drive(1, 0, 0, 8'h00, 8'h00, 0);
        reset = 1'b0;
        tick(); tick();
        reset = 1'b1;
        tick();
    endtask

    // scenarios
    task automatic test_reset();
        reset = 1'b0;
        drive(0, 1, 1, 8'hFF, 8'hFF, 1);
        drive(1, 1, 0, 8'hEE, 8'h11, 1);
        tick(); tick();
        checks++; if (gnt !== 2'b00) begin errors++; $display("FAIL reset_gnt: got %b exp 00", gnt); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b exp 0", busy); end
        checks++; if ({r0_ack, r1_ack} !== 2'b00) begin errors++; $display("FAIL reset_ack: got %b exp 00", {r0_ack, r1_ack}); end
        checks++; if ({mem_rd, mem_wrt} !== 2'b00) begin errors++; $display("FAIL reset_strobe: got %b exp 00", {mem_rd, mem_wrt}); end
        checks++; if ({mem_add, mem_dout} !== 16'h0000) begin errors++; $display("FAIL reset_bus: got %h exp 0000", {mem_add, mem_dout}); end
        checks++; if ({r0_rdat, r1_rdat} !== 16'h0000) begin errors++; $display("FAIL reset_rdat: got %h exp 0000", {r0_rdat, r1_rdat}); end
        drive(0, 0, 0, 8'h00, 8'h00, 0);
        drive(1, 0, 0, 8'h00, 8'h00, 0);
        reset = 1'b1;
        tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_release_busy: got %b exp 0", busy); end
    endtask

    task automatic test_read();
        int r0c, w0c;
        mem[8'h10] = 8'hA5;
        ack_log.delete();
        r0c = rd_cnt; w0c = wr_cnt;
        drive(0, 1, 0, 8'h10, 8'h00, 0);
        tick();
        checks++; if (mem_rd !== 1'b1 || mem_wrt !== 1'b0) begin errors++; $display("FAIL read_strobe: rd=%b wrt=%b exp 1/0", mem_rd, mem_wrt); end
        checks++; if (mem_add !== 8'h10) begin errors++; $display("FAIL read_add: got %h exp 10", mem_add); end
        checks++; if (gnt !== 2'b01 || busy !== 1'b1) begin errors++; $display("FAIL read_gnt: gnt=%b busy=%b exp 01/1", gnt, busy); end
        drive(0, 0, 0, 8'h10, 8'h00, 0);
        tick();
        checks++; if (r0_ack !== 1'b1 || r1_ack !== 1'b0) begin errors++; $display("FAIL read_ack: ack0=%b ack1=%b exp 1/0", r0_ack, r1_ack); end
        checks++; if (r0_rdat !== 8'hA5) begin errors++; $display("FAIL read_rdat: got %h exp a5", r0_rdat); end
        tick();
        checks++; if (r0_ack !== 1'b0 || gnt !== 2'b00 || busy !== 1'b0) begin errors++; $display("FAIL read_after: ack=%b gnt=%b busy=%b exp 0/00/0", r0_ack, gnt, busy); end
        checks++; if (r0_rdat !== 8'hA5) begin errors++; $display("FAIL read_rdat_hold: got %h exp a5", r0_rdat); end
        tick();
        checks++; if (ack_log.size() !== 1) begin errors++; $display("FAIL read_ack_count: got %0d exp 1", ack_log.size()); end
        checks++; if (rd_cnt - r0c !== 1 || wr_cnt - w0c !== 0) begin errors++; $display("FAIL read_strobe_count: rd=%0d wrt=%0d exp 1/0", rd_cnt - r0c, wr_cnt - w0c); end
    endtask

    task automatic test_write();
        int r0c, w0c;
        mem[8'h20] = 8'h00;
        ack_log.delete();
        r0c = rd_cnt; w0c = wr_cnt;
        drive(1, 1, 1, 8'h20, 8'h3C, 0);
        tick();
        checks++; if (mem_wrt !== 1'b1 || mem_rd !== 1'b0) begin errors++; $display("FAIL write_strobe: rd=%b wrt=%b exp 0/1", mem_rd, mem_wrt); end
        checks++; if (mem_add !== 8'h20 || mem_dout !== 8'h3C) begin errors++; $display("FAIL write_bus: add=%h dout=%h exp 20/3c", mem_add, mem_dout); end
        checks++; if (gnt !== 2'b10) begin errors++; $display("FAIL write_gnt: got %b exp 10", gnt); end
        tick();
        checks++; if (r1_ack !== 1'b1 || r0_ack !== 1'b0 || mem_wrt !== 1'b0) begin errors++; $display("FAIL write_ack: ack1=%b ack0=%b wrt=%b exp 1/0/0", r1_ack, r0_ack, mem_wrt); end
        drive(1, 0, 0, 8'h00, 8'h00, 0);
        tick(); tick();
        checks++; if (mem[8'h20] !== 8'h3C) begin errors++; $display("FAIL write_mem: got %h exp 3c", mem[8'h20]); end
        checks++; if (ack_log.size() !== 1 || gnt !== 2'b00) begin errors++; $display("FAIL write_after: acks=%0d gnt=%b exp 1/00", ack_log.size(), gnt); end
        checks++; if (rd_cnt - r0c !== 0 || wr_cnt - w0c !== 1) begin errors++; $display("FAIL write_strobe_count: rd=%0d wrt=%0d exp 0/1", rd_cnt - r0c, wr_cnt - w0c); end
    endtask

    task automatic test_tie();
        int last, win, seen;
        logic [1:0] e, obs;
        logic [7:0] got, want;
        pulse_reset();
        last = 1;
        for (int i = 0; i < 4; i++) begin
`ifdef ARB_ROUND_ROBIN_EN
            win = 1 - last;
`else
            win = 0;
`endif
            last = win;
            exp_q.push_back(win == 1 ? 2'b10 : 2'b01);
        end
        mem[8'h60] = 8'hC1;
        mem[8'h61] = 8'hC2;
        drive(0, 1, 0, 8'h60, 8'h00, 0);
        drive(1, 1, 0, 8'h61, 8'h00, 0);
        seen = 0;
        for (int k = 0; k < 20 && seen < 4; k++) begin
            tick();
            if (r0_ack || r1_ack) begin
                obs = {r1_ack, r0_ack};
                e = exp_q.pop_front();
                checks++; if (obs !== e) begin errors++; $display("FAIL tie_order%0d: got %b exp %b", seen, obs, e); end
                got  = r1_ack ? r1_rdat : r0_rdat;
                want = r1_ack ? 8'hC2 : 8'hC1;
                checks++; if (got !== want) begin errors++; $display("FAIL tie_rdat%0d: got %h exp %h", seen, got, want); end
                seen++;
            end
        end
        checks++; if (seen !== 4) begin errors++; $display("FAIL tie_timeout: got %0d acks exp 4", seen); end
        exp_q.delete();
        drive(0, 0, 0, 8'h00, 8'h00, 0);
        drive(1, 0, 0, 8'h00, 8'h00, 0);
        tick(); tick();
    endtask

    task automatic test_lock();
        int b;
        int ec[3] = '{2, 5, 8};
        int ep[3] = '{1, 1, 0};
        mem[8'h30] = 8'h5A;
        mem[8'h50] = 8'h11;
        ack_log.delete();
        b = cyc;
        drive(1, 1, 0, 8'h30, 8'h00, 1);
        tick();
        drive(0, 1, 0, 8'h50, 8'h00, 0);
        tick();
        drive(1, 1, 1, 8'h30, 8'h77, 1);
        tick();
        checks++; if (gnt !== 2'b10) begin errors++; $display("FAIL lock_gnt_held: got %b exp 10", gnt); end
        drive(1, 1, 1, 8'h30, 8'h77, 0);
        tick(); tick();
        drive(1, 0, 0, 8'h00, 8'h00, 0);
        tick(); tick(); tick();
        drive(0, 0, 0, 8'h00, 8'h00, 0);
        tick();
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (i >= ack_log.size() || ack_log[i].c - b !== ec[i] || ack_log[i].p !== ep[i]) begin
                errors++;
                $display("FAIL lock_seq%0d: log size %0d, exp port %0d at +%0d", i, ack_log.size(), ep[i], ec[i]);
            end
        end
        checks++; if (ack_log.size() !== 3) begin errors++; $display("FAIL lock_ack_count: got %0d exp 3", ack_log.size()); end
        checks++; if (r1_rdat !== 8'h5A) begin errors++; $display("FAIL lock_r1_rdat: got %h exp 5a", r1_rdat); end
        checks++; if (r0_rdat !== 8'h11) begin errors++; $display("FAIL lock_r0_rdat: got %h exp 11", r0_rdat); end
        checks++; if (mem[8'h30] !== 8'h77) begin errors++; $display("FAIL lock_mem: got %h exp 77", mem[8'h30]); end
    endtask

    task automatic test_lock_hold();
        int b;
        int ec[2] = '{2, 8};
        int ep[2] = '{1, 0};
        mem[8'h31] = 8'h42;
        mem[8'h50] = 8'h2B;
        ack_log.delete();
        b = cyc;
        drive(1, 1, 0, 8'h31, 8'h00, 1);
        tick();
        drive(0, 1, 0, 8'h50, 8'h00, 0);
        tick();
        drive(1, 0, 0, 8'h31, 8'h00, 1);
        tick(); tick();
        checks++; if (gnt !== 2'b10 || busy !== 1'b0) begin errors++; $display("FAIL hold_gnt_a: gnt=%b busy=%b exp 10/0", gnt, busy); end
        tick();
        checks++; if (gnt !== 2'b10) begin errors++; $display("FAIL hold_gnt_b: got %b exp 10", gnt); end
        tick();
        drive(1, 0, 0, 8'h00, 8'h00, 0);
        tick();
        checks++; if (gnt !== 2'b01 || busy !== 1'b1) begin errors++; $display("FAIL hold_release: gnt=%b busy=%b exp 01/1", gnt, busy); end
        tick();
        drive(0, 0, 0, 8'h00, 8'h00, 0);
        tick();
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (i >= ack_log.size() || ack_log[i].c - b !== ec[i] || ack_log[i].p !== ep[i]) begin
                errors++;
                $display("FAIL hold_seq%0d: log size %0d, exp port %0d at +%0d", i, ack_log.size(), ep[i], ec[i]);
            end
        end
        checks++; if (r0_rdat !== 8'h2B || r1_rdat !== 8'h42) begin errors++; $display("FAIL hold_rdat: r0=%h r1=%h exp 2b/42", r0_rdat, r1_rdat); end
    endtask

    task automatic test_reset_mid();
        mem[8'h40] = 8'h5E;
        ack_log.delete();
        drive(0, 1, 1, 8'h40, 8'h99, 0);
        tick();
        checks++; if (mem_wrt !== 1'b1) begin errors++; $display("FAIL rstmid_pre: wrt=%b exp 1", mem_wrt); end
        #2 reset = 1'b0;
        #1;
        checks++; if (mem_wrt !== 1'b0 || mem_rd !== 1'b0) begin errors++; $display("FAIL rstmid_strobe: rd=%b wrt=%b exp 0/0", mem_rd, mem_wrt); end
        checks++; if (gnt !== 2'b00 || busy !== 1'b0) begin errors++; $display("FAIL rstmid_state: gnt=%b busy=%b exp 00/0", gnt, busy); end
        drive(0, 0, 0, 8'h00, 8'h00, 0);
        tick(); tick();
        reset = 1'b1;
        tick(); tick();
        checks++; if (ack_log.size() !== 0) begin errors++; $display("FAIL rstmid_noack: got %0d acks exp 0", ack_log.size()); end
        checks++; if (mem[8'h40] !== 8'h5E) begin errors++; $display("FAIL rstmid_mem: got %h exp 5e", mem[8'h40]); end
        drive(0, 1, 0, 8'h40, 8'h00, 0);
        tick(); tick();
        checks++; if (r0_ack !== 1'b1 || r0_rdat !== 8'h5E) begin errors++; $display("FAIL rstmid_after: ack=%b rdat=%h exp 1/5e", r0_ack, r0_rdat); end
        drive(0, 0, 0, 8'h00, 8'h00, 0);
        tick();
    endtask

    task automatic test_random();
        logic [7:0] model_mem [256];
        logic       op_we [2];
        logic [7:0] op_add [2];
        logic [7:0] op_wdat [2];
        logic [1:0] e, obs;
        logic [7:0] got;
        int last, mode, w, t, nack, p, ep;
        pulse_reset();
        for (int i = 0; i < 256; i++) begin
            mem[i] = 8'($urandom);
            model_mem[i] = mem[i];
        end
        last = 1;
        for (int it = 0; it < 40; it++) begin
            mode = $urandom_range(0, 2);
            for (int q = 0; q < 2; q++) begin
                op_we[q]   = 1'($urandom_range(0, 1));
                op_add[q]  = 8'($urandom_range(0, 15));
                op_wdat[q] = 8'($urandom);
            end
            if (mode == 2) begin
`ifdef ARB_ROUND_ROBIN_EN
                w = 1 - last;
`else
                w = 0;
`endif
                exp_q.push_back(w == 1 ? 2'b10 : 2'b01);
                exp_q.push_back(w == 1 ? 2'b01 : 2'b10);
                last = 1 - w;
            end else begin
                exp_q.push_back(mode == 1 ? 2'b10 : 2'b01);
                last = mode;
            end
            for (int q = 0; q < 2; q++)
                drive(q, (mode == 2) || (mode == q), op_we[q], op_add[q], op_wdat[q], 0);
            t = 0;
            nack = 0;
            for (int k = 0; k < 15 && exp_q.size() > 0; k++) begin
                tick();
                t++;
                if (r0_ack || r1_ack) begin
                    obs = {r1_ack, r0_ack};
                    e = exp_q.pop_front();
                    ep = e[1] ? 1 : 0;
                    p = r1_ack ? 1 : 0;
                    checks++; if (obs !== e) begin errors++; $display("FAIL rand_order it%0d: got %b exp %b", it, obs, e); end
                    checks++; if (t !== (nack == 0 ? 2 : 5)) begin errors++; $display("FAIL rand_latency it%0d: got %0d exp %0d", it, t, nack == 0 ? 2 : 5); end
                    if (op_we[ep]) begin
                        model_mem[op_add[ep]] = op_wdat[ep];
                    end else begin
                        got = ep ? r1_rdat : r0_rdat;
                        checks++; if (got !== model_mem[op_add[ep]]) begin errors++; $display("FAIL rand_rdat it%0d: got %h exp %h", it, got, model_mem[op_add[ep]]); end
                    end
                    drive(p, 0, 0, 8'h00, 8'h00, 0);
                    nack++;
                end
            end
            if (exp_q.size() > 0) begin
                checks++;
                errors++;
                $display("FAIL rand_timeout it%0d: got %0d acks exp %0d", it, nack, nack + exp_q.size());
                exp_q.delete();
                drive(0, 0, 0, 8'h00, 8'h00, 0);
                drive(1, 0, 0, 8'h00, 8'h00, 0);
                tick(); tick(); tick();
            end
            tick();
        end
        for (int a = 0; a < 16; a++) begin
            checks++;
            if (mem[a] !== model_mem[a]) begin errors++; $display("FAIL rand_mem[%0d]: got %h exp %h", a, mem[a], model_mem[a]); end
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        drive(0, 0, 0, 8'h00, 8'h00, 0);
        drive(1, 0, 0, 8'h00, 8'h00, 0);
        test_reset();
        test_read();
        test_write();
        test_tie();
        test_lock();
        test_lock_hold();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
